// File: rtl/banco_registradores.sv
// Register bank: 2^LARGURA_END words, r0 hardwired to zero, one write port, two combinational reads.
// Define BANCO_REGISTRADORES_BYPASS_WB_EN to forward the write port to same-cycle reads.
module banco_registradores #(
  parameter int LARGURA_DADO = 32,
  parameter int LARGURA_END  = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    escritaHabilitada,
  input  logic [LARGURA_END-1:0]  registroEscrita,
  input  logic [LARGURA_DADO-1:0] dadoEscrita,
  input  logic [LARGURA_END-1:0]  registroLeituraA,
  input  logic [LARGURA_END-1:0]  registroLeituraB,
  output logic [LARGURA_DADO-1:0] dadoLeituraA,
  output logic [LARGURA_DADO-1:0] dadoLeituraB
);

  localparam int NUM_REGS = 1 << LARGURA_END;

  logic [LARGURA_DADO-1:0] bancoRegs [NUM_REGS];
  logic                    escritaValida;

  // r0 is never written, so its slot stays at the reset value forever.
  assign escritaValida = escritaHabilitada && (registroEscrita != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        bancoRegs[i] <= '0;
      end
    end else if (escritaValida) begin
      bancoRegs[registroEscrita] <= dadoEscrita;
    end
  end

  always_comb begin
    dadoLeituraA = '0;
    if (!reset && (registroLeituraA != '0)) begin
      dadoLeituraA = bancoRegs[registroLeituraA];
`ifdef BANCO_REGISTRADORES_BYPASS_WB_EN
      if (escritaValida && (registroEscrita == registroLeituraA)) begin
        dadoLeituraA = dadoEscrita;
      end
`endif
    end
  end

  always_comb begin
    dadoLeituraB = '0;
    if (!reset && (registroLeituraB != '0)) begin
      dadoLeituraB = bancoRegs[registroLeituraB];
`ifdef BANCO_REGISTRADORES_BYPASS_WB_EN
      if (escritaValida && (registroEscrita == registroLeituraB)) begin
        dadoLeituraB = dadoEscrita;
      end
`endif
    end
  end

endmodule

// File: tb/tb_banco_registradores.sv
// Directed + random bench for banco_registradores against an array-based reference model.
module tb_banco_registradores;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int N  = 1 << AW;
`ifdef BANCO_REGISTRADORES_BYPASS_WB_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic          escritaHabilitada;
  logic [AW-1:0] registroEscrita;
  logic [W-1:0]  dadoEscrita;
  logic [AW-1:0] registroLeituraA;
  logic [AW-1:0] registroLeituraB;
  logic [W-1:0]  dadoLeituraA;
  logic [W-1:0]  dadoLeituraB;

  logic [W-1:0] ref_mem [N];
  logic [W-1:0] exp_q [$];
  int checks = 0;
  int passed = 0;
  int fails  = 0;

  banco_registradores #(.LARGURA_DADO(W), .LARGURA_END(AW)) dut (
    .clock            (clock),
    .reset            (reset),
    .escritaHabilitada(escritaHabilitada),
    .registroEscrita  (registroEscrita),
    .dadoEscrita      (dadoEscrita),
    .registroLeituraA (registroLeituraA),
    .registroLeituraB (registroLeituraB),
    .dadoLeituraA     (dadoLeituraA),
    .dadoLeituraB     (dadoLeituraB)
  );

  // clock / watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: what a read of idx must show given the currently driven inputs
  function automatic logic [W-1:0] model_read(input logic [AW-1:0] idx);
    if (reset || idx == 0) return '0;
    if (BYPASS && escritaHabilitada && registroEscrita != 0 && registroEscrita == idx)
      return dadoEscrita;
    return ref_mem[idx];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) ref_mem[i] = '0;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs);
    logic [W-1:0] exp;
    exp = exp_q.pop_front();
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reads(input string tag);
    exp_q.push_back(model_read(registroLeituraA));
    exp_q.push_back(model_read(registroLeituraB));
    check({tag, "_A"}, dadoLeituraA);
    check({tag, "_B"}, dadoLeituraB);
  endtask

  // driver: present one cycle of inputs, check reads before the edge, commit model at the edge
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                      input logic [AW-1:0] ra, input logic [AW-1:0] rb, input string tag);
    @(negedge clock);
    escritaHabilitada = we;
    registroEscrita   = wa;
    dadoEscrita       = wd;
    registroLeituraA  = ra;
    registroLeituraB  = rb;
    #2;
    check_reads(tag);
    @(posedge clock);
    if (!reset && we && wa != 0) ref_mem[wa] = wd;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    escritaHabilitada = 1'b0;
    registroEscrita = '0;
    dadoEscrita = '0;
    registroLeituraA = 5'd5;
    registroLeituraB = 5'd31;
    model_clear();
    #1;
    check_reads("reset_hold");
    @(negedge clock);
    dadoEscrita = 32'h1234_5678;
    escritaHabilitada = 1'b1;
    registroEscrita = 5'd5;
    #2;
    check_reads("reset_write_ignored");
    @(negedge clock);
    reset = 1'b0;
    escritaHabilitada = 1'b0;

    for (int i = 0; i < N; i++) step(1'b0, '0, '0, i[AW-1:0], 5'(N - 1 - i), "after_reset");

    step(1'b1, 5'd5, 32'd10, 5'd0, 5'd0, "wr_r5");
    step(1'b1, 5'd6, 32'd20, 5'd0, 5'd0, "wr_r6");
    step(1'b0, '0, '0, 5'd5, 5'd6, "rd_r5_r6");

    step(1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0, "wr_r0_same_cycle");
    step(1'b0, '0, '0, 5'd0, 5'd0, "rd_r0");

    step(1'b0, 5'd7, 32'd55, 5'd7, 5'd7, "we_off_r7");
    step(1'b0, '0, '0, 5'd7, 5'd6, "rd_r7");

    step(1'b1, 5'd9, 32'd12, 5'd0, 5'd0, "wr_r9_12");
    step(1'b1, 5'd9, 32'd30, 5'd9, 5'd9, "wr_r9_30_same_cycle");
    step(1'b0, '0, '0, 5'd9, 5'd9, "rd_r9_after");

    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), "random");
    end

    // asynchronous reset between edges with a write pending
    step(1'b1, 5'd3, 32'd77, 5'd0, 5'd0, "wr_r3_77");
    @(negedge clock);
    escritaHabilitada = 1'b1;
    registroEscrita   = 5'd3;
    dadoEscrita       = 32'd99;
    registroLeituraA  = 5'd3;
    registroLeituraB  = 5'd5;
    #2;
    check_reads("pre_async_reset");
    reset = 1'b1;
    model_clear();
    #1;
    check_reads("async_reset_now");
    @(posedge clock);
    #1;
    check_reads("async_reset_edge");
    @(negedge clock);
    reset = 1'b0;
    escritaHabilitada = 1'b0;
    step(1'b0, '0, '0, 5'd3, 5'd5, "rd_r3_after_reset");
    step(1'b1, 5'd4, 32'hCAFE_F00D, 5'd4, 5'd3, "first_write_after_reset");
    step(1'b0, '0, '0, 5'd4, 5'd4, "rd_r4");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
